// File: rtl/int_div_pkg.sv
// Types and reset constant for the iterative integer divider.
package int_div_pkg;
  import river_cfg_pkg::*;

  localparam int XLEN = RISCV_ARCH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef struct packed {
    state_t          state;
    logic [6:0]      cnt;
    logic [XLEN-1:0] divisor;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quot;
    logic            neg_q;
    logic            neg_r;
    logic            residual;
    logic            rv32;
    logic [XLEN-1:0] res;
    logic            valid;
  } IntDiv_registers;

  localparam IntDiv_registers IntDiv_r_reset = '{
    state:    IDLE,
    cnt:      7'd0,
    divisor:  64'd0,
    rem:      65'd0,
    quot:     64'd0,
    neg_q:    1'b0,
    neg_r:    1'b0,
    residual: 1'b0,
    rv32:     1'b0,
    res:      64'd0,
    valid:    1'b0
  };
endpackage : int_div_pkg

// File: rtl/river_cfg_pkg.sv
// Core-wide configuration constants shared by the River pipeline units.
package river_cfg_pkg;
  localparam int RISCV_ARCH = 64;
endpackage : river_cfg_pkg

// File: rtl/int_div.sv
// Iterative restoring radix-2 divider for RV64 DIV/DIVU/REM/REMU and their W variants.
// Divide-by-zero and signed overflow skip the iteration and go straight to FIX.
module int_div
  import int_div_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ena,
  input  logic            i_unsigned,
  input  logic            i_rv32,
  input  logic            i_residual,
  input  logic [XLEN-1:0] i_a1,
  input  logic [XLEN-1:0] i_a2,
  output logic [XLEN-1:0] o_res,
  output logic            o_valid,
  output logic            o_busy
);

  IntDiv_registers r_q;
  IntDiv_registers w_d;

  logic [XLEN-1:0] w_a1_ext, w_a2_ext, w_a1_abs, w_a2_abs, w_min_neg;
  logic [XLEN-1:0] w_q_fix, w_r_fix, w_sel;
  logic            w_a1_neg, w_a2_neg, w_div_zero, w_ovf;
  logic [XLEN+1:0] w_shl, w_diff;

  assign w_a1_ext = i_rv32 ? (i_unsigned ? {32'h0, i_a1[31:0]} : {{32{i_a1[31]}}, i_a1[31:0]}) : i_a1;
  assign w_a2_ext = i_rv32 ? (i_unsigned ? {32'h0, i_a2[31:0]} : {{32{i_a2[31]}}, i_a2[31:0]}) : i_a2;
  assign w_a1_neg = ~i_unsigned & w_a1_ext[63];
  assign w_a2_neg = ~i_unsigned & w_a2_ext[63];
  assign w_a1_abs = w_a1_neg ? (64'd0 - w_a1_ext) : w_a1_ext;
  assign w_a2_abs = w_a2_neg ? (64'd0 - w_a2_ext) : w_a2_ext;
  assign w_div_zero = (w_a2_ext == 64'd0);
  assign w_min_neg  = i_rv32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign w_ovf      = ~i_unsigned & (w_a1_ext == w_min_neg) & (w_a2_ext == 64'hFFFF_FFFF_FFFF_FFFF);

  // One extra guard bit keeps the borrow visible even when the shifted remainder needs 65 bits.
  assign w_shl  = {r_q.rem, r_q.quot[63]};
  assign w_diff = w_shl - {2'b00, r_q.divisor};

  assign w_q_fix = r_q.neg_q ? (64'd0 - r_q.quot) : r_q.quot;
  assign w_r_fix = r_q.neg_r ? (64'd0 - r_q.rem[63:0]) : r_q.rem[63:0];
  assign w_sel   = r_q.residual ? w_r_fix : w_q_fix;

  assign o_res   = r_q.res;
  assign o_valid = r_q.valid;
  assign o_busy  = (r_q.state != IDLE);

  always_comb begin
    w_d       = r_q;
    w_d.valid = 1'b0;
    case (r_q.state)
      IDLE: begin
        if (i_ena) begin
          w_d.residual = i_residual;
          w_d.rv32     = i_rv32;
          w_d.divisor  = w_a2_abs;
          w_d.cnt      = i_rv32 ? 7'd31 : 7'd63;
          if (w_div_zero) begin
            w_d.quot  = 64'hFFFF_FFFF_FFFF_FFFF;
            w_d.rem   = {1'b0, w_a1_ext};
            w_d.neg_q = 1'b0;
            w_d.neg_r = 1'b0;
            w_d.state = FIX;
          end else if (w_ovf) begin
            w_d.quot  = w_a1_ext;
            w_d.rem   = 65'd0;
            w_d.neg_q = 1'b0;
            w_d.neg_r = 1'b0;
            w_d.state = FIX;
          end else begin
            // W variants park the 32-bit dividend in the top half so 32 shifts consume it.
            w_d.quot  = i_rv32 ? {w_a1_abs[31:0], 32'h0} : w_a1_abs;
            w_d.rem   = 65'd0;
            w_d.neg_q = w_a1_neg ^ w_a2_neg;
            w_d.neg_r = w_a1_neg;
            w_d.state = CALC;
          end
        end else begin
          w_d.state = IDLE;
        end
      end
      CALC: begin
        w_d.rem  = w_diff[65] ? w_shl[64:0] : w_diff[64:0];
        w_d.quot = {r_q.quot[62:0], ~w_diff[65]};
        if (r_q.cnt == 7'd0) begin
          w_d.state = FIX;
        end else begin
          w_d.cnt = r_q.cnt - 7'd1;
        end
      end
      FIX: begin
        w_d.res   = r_q.rv32 ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
        w_d.valid = 1'b1;
        w_d.state = IDLE;
      end
      default: begin
        w_d = IntDiv_r_reset;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= IntDiv_r_reset;
    end else begin
      r_q <= w_d;
    end
  end

endmodule : int_div
